mem_stage: RTL

- Memory stage of the Y86-64 pipeline. Consumes the M pipeline-register fields and performs the data-memory access: mrmovq/popq/ret read; rmmovq/pushq/call write.
- Computes the memory-stage status and forwarding values, and holds the W pipeline register feeding writeback.
- Contains a byte-addressed little-endian data memory with 8-byte accesses.

---
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Bundles the M pipeline-register fields, the W pipeline-register controls
//   and every output of the memory stage.
//
//   M-side (into the stage):  M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM
//   W control (into stage):   W_stall, W_bubble
//   Combinational outputs:    m_stat, m_valM
//   Registered W outputs:     W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
//
//   master: the pipeline side that drives M fields / W controls.
//   slave:  the memory stage itself.
interface mem_stage_if;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        W_stall;
    logic        W_bubble;

    logic [1:0]  m_stat;
    logic [63:0] m_valM;

    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    modport master (
        output M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM,
        output W_stall, W_bubble,
        input  m_stat, m_valM,
        input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

    modport slave (
        input  M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM,
        input  W_stall, W_bubble,
        output m_stat, m_valM,
        output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   Memory stage of the Y86-64 pipeline. Performs the data-memory access for
//   the instruction in M (mrmovq/popq/ret read, rmmovq/pushq/call write),
//   produces the memory-stage status and forwarded read data, and holds the
//   W pipeline register.
//
//   Ports:
//     clk    rising-edge clock for memory writes and the W register
//     reset  synchronous active-high; loads a bubble into W, blocks writes
//     bus    mem_stage_if.slave: M fields, W stall/bubble, m_stat/m_valM,
//            and the registered W fields
//
//   Data memory is byte-addressed, little-endian, 8-byte accesses, and is
//   not cleared by reset.
module mem_stage #(
    parameter int         MEM_BYTES = 1024,
    parameter logic [1:0] STAT_AOK  = 2'd0,
    parameter logic [1:0] STAT_HLT  = 2'd1,
    parameter logic [1:0] STAT_ADR  = 2'd2,
    parameter logic [1:0] STAT_INS  = 2'd3
) (
    input logic         clk,
    input logic         reset,
    mem_stage_if.slave  bus
);

    localparam int          AW        = $clog2(MEM_BYTES);
    localparam logic [63:0] ADDR_LAST = 64'(MEM_BYTES - 8);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    logic [7:0]    mem [MEM_BYTES];

    logic          mem_read;
    logic          mem_write;
    logic [63:0]   mem_addr;
    logic          dmem_error;
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [63:0]   rd_data;

    assign mem_read  = (bus.M_icode == I_MRMOVQ) || (bus.M_icode == I_RET) ||
                       (bus.M_icode == I_POPQ);
    assign mem_write = (bus.M_icode == I_RMMOVQ) || (bus.M_icode == I_CALL) ||
                       (bus.M_icode == I_PUSHQ);

    // ret/popq address the stack through valA; everything else uses valE.
    assign mem_addr = ((bus.M_icode == I_RET) || (bus.M_icode == I_POPQ)) ?
                      bus.M_valA : bus.M_valE;

    // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
    assign dmem_error = (mem_read || mem_write) && (mem_addr > ADDR_LAST);

    assign bus.m_stat = dmem_error ? STAT_ADR : bus.M_stat;

    // An excepting instruction already sitting in W must not let a younger
    // store modify memory.
    assign mem_we = mem_write && !dmem_error && (bus.M_stat == STAT_AOK) &&
                    (bus.W_stat == STAT_AOK) && !reset;

    // Only the low address bits index the array; the range check above
    // guarantees idx+7 stays inside it whenever the access is used.
    assign mem_idx = mem_addr[AW-1:0];

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            rd_data[8*k +: 8] = mem[mem_idx + AW'(k)];
        end
    end

    assign bus.m_valM = (mem_read && !dmem_error) ? rd_data : 64'd0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                mem[mem_idx + AW'(k)] <= bus.M_valA[8*k +: 8];
            end
        end
    end

    // W pipeline register: reset, then stall, then bubble, then normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.W_stat  <= STAT_AOK;
            bus.W_icode <= I_NOP;
            bus.W_valE  <= 64'd0;
            bus.W_valM  <= 64'd0;
            bus.W_dstE  <= REG_NONE;
            bus.W_dstM  <= REG_NONE;
        end else if (bus.W_stall) begin
            bus.W_stat  <= bus.W_stat;
            bus.W_icode <= bus.W_icode;
            bus.W_valE  <= bus.W_valE;
            bus.W_valM  <= bus.W_valM;
            bus.W_dstE  <= bus.W_dstE;
            bus.W_dstM  <= bus.W_dstM;
        end else if (bus.W_bubble) begin
            bus.W_stat  <= STAT_AOK;
            bus.W_icode <= I_NOP;
            bus.W_valE  <= 64'd0;
            bus.W_valM  <= 64'd0;
            bus.W_dstE  <= REG_NONE;
            bus.W_dstM  <= REG_NONE;
        end else begin
            bus.W_stat  <= bus.m_stat;
            bus.W_icode <= bus.M_icode;
            bus.W_valE  <= bus.M_valE;
            bus.W_valM  <= bus.m_valM;
            bus.W_dstE  <= bus.M_dstE;
            bus.W_dstM  <= bus.M_dstM;
        end
    end

endmodule
